as_gpio_seq_monitor: RTL and testbench

- Synthesizable self-check monitor for integration runs of the RV64I core.
- Watches the core's GPIO chip-select strobe and GPIO data bus, and compares each strobe event against a programmable expected-value sequence with per-entry bit masks.
- Reports pass or fail, the failing step index and data, and a watchdog timeout.
- Sits beside as_top_mem so that the pass/fail checking normally done in the bench can also run in hardware (FPGA or emulation).

---
 rtl/as_gpio_seq_monitor_if.sv | 38 +++
 rtl/as_gpio_seq_monitor.sv | 159 +++++++++++++++
 tb/tb_as_gpio_seq_monitor.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/as_gpio_seq_monitor_if.sv
// Configuration, GPIO observation and status bundle of the GPIO sequence monitor.
interface as_gpio_seq_monitor_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TO_W   = 16
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  logic              cfg_we_i;
  logic [AW-1:0]     cfg_addr_i;
  logic [DATA_W-1:0] cfg_data_i;
  logic [DATA_W-1:0] cfg_mask_i;
  logic [SW-1:0]     cfg_len_i;
  logic [TO_W-1:0]   to_limit_i;
  logic              arm_i;
  logic              cs_i;
  logic [DATA_W-1:0] gpio_i;
  logic              busy_o;
  logic              pass_o;
  logic              fail_o;
  logic              timeout_o;
  logic [SW-1:0]     step_o;
  logic [AW-1:0]     fail_idx_o;
  logic [DATA_W-1:0] fail_data_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_data_i, cfg_mask_i, cfg_len_i, to_limit_i,
           arm_i, cs_i, gpio_i,
    input  busy_o, pass_o, fail_o, timeout_o, step_o, fail_idx_o, fail_data_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_data_i, cfg_mask_i, cfg_len_i, to_limit_i,
           arm_i, cs_i, gpio_i,
    output busy_o, pass_o, fail_o, timeout_o, step_o, fail_idx_o, fail_data_o
  );
endinterface

// File: rtl/as_gpio_seq_monitor.sv
// Hardware self-check: compares GPIO strobe events against a programmable masked
// expected-value sequence and reports pass, fail (with step/data) or watchdog timeout.
module as_gpio_seq_monitor #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TO_W      = 16,
  parameter int unsigned EDGE_MODE = 1
) (
  input logic                  clk_i,
  input logic                  rstn_i,
  as_gpio_seq_monitor_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_PASS, ST_FAIL} state_e;

  state_e            state_q, state_d;
  logic              cs_prev_q, cs_prev_d;
  logic [SW-1:0]     step_q, step_d;
  logic [SW-1:0]     len_q, len_d;
  logic [TO_W-1:0]   to_lim_q, to_lim_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              pass_q, pass_d;
  logic              fail_q, fail_d;
  logic              timeout_q, timeout_d;
  logic [AW-1:0]     fail_idx_q, fail_idx_d;
  logic [DATA_W-1:0] fail_data_q, fail_data_d;

  logic [DATA_W-1:0] exp_q  [DEPTH];
  logic [DATA_W-1:0] mask_q [DEPTH];

  logic              evt;
  logic              match;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     last_idx;
  logic [SW-1:0]     step_inc;
  logic [TO_W-1:0]   wd_inc;

  // Table has no reset: its contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (bus.cfg_we_i) begin
      exp_q[bus.cfg_addr_i]  <= bus.cfg_data_i;
      mask_q[bus.cfg_addr_i] <= bus.cfg_mask_i;
    end
  end

  assign evt = (EDGE_MODE != 0) ? (bus.cs_i & ~cs_prev_q) : bus.cs_i;

  always_comb begin
    state_d     = state_q;
    cs_prev_d   = bus.cs_i;
    step_d      = step_q;
    len_d       = len_q;
    to_lim_d    = to_lim_q;
    wd_d        = wd_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    timeout_d   = timeout_q;
    fail_idx_d  = fail_idx_q;
    fail_data_d = fail_data_q;

    idx      = step_q[AW-1:0];
    match    = ((bus.gpio_i ^ exp_q[idx]) & mask_q[idx]) == '0;
    step_inc = step_q + SW'(1);
    wd_inc   = (wd_q == '1) ? wd_q : wd_q + TO_W'(1);
    last_idx = AW'(len_q - SW'(1));

    // arm takes priority over any event in the same cycle, in every state
    if (bus.arm_i) begin
      state_d     = ST_ARMED;
      step_d      = '0;
      len_d       = (bus.cfg_len_i == '0) ? SW'(1) : bus.cfg_len_i;
      to_lim_d    = bus.to_limit_i;
      wd_d        = '0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      timeout_d   = 1'b0;
      fail_idx_d  = '0;
      fail_data_d = '0;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (evt) begin
            wd_d = '0;
            if (match) begin
              step_d = step_inc;
              if (step_inc == len_q) begin
                pass_d  = 1'b1;
                state_d = ST_PASS;
              end
            end else begin
              fail_d      = 1'b1;
              fail_idx_d  = idx;
              fail_data_d = bus.gpio_i;
              state_d     = ST_FAIL;
            end
          end else if (to_lim_q != '0) begin
            wd_d = wd_inc;
            if (wd_inc == to_lim_q) begin
              fail_d      = 1'b1;
              timeout_d   = 1'b1;
              fail_idx_d  = idx;
              fail_data_d = bus.gpio_i;
              state_d     = ST_FAIL;
            end
          end
        end
        ST_PASS: begin
          if (evt) begin
            pass_d      = 1'b0;
            fail_d      = 1'b1;
            fail_idx_d  = last_idx;
            fail_data_d = bus.gpio_i;
            state_d     = ST_FAIL;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= ST_IDLE;
      cs_prev_q   <= 1'b0;
      step_q      <= '0;
      len_q       <= '0;
      to_lim_q    <= '0;
      wd_q        <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_idx_q  <= '0;
      fail_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cs_prev_q   <= cs_prev_d;
      step_q      <= step_d;
      len_q       <= len_d;
      to_lim_q    <= to_lim_d;
      wd_q        <= wd_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      fail_idx_q  <= fail_idx_d;
      fail_data_q <= fail_data_d;
    end
  end

  assign bus.busy_o      = (state_q == ST_ARMED);
  assign bus.pass_o      = pass_q;
  assign bus.fail_o      = fail_q;
  assign bus.timeout_o   = timeout_q;
  assign bus.step_o      = step_q;
  assign bus.fail_idx_o  = fail_idx_q;
  assign bus.fail_data_o = fail_data_q;

endmodule

// File: tb/tb_as_gpio_seq_monitor.sv
// Directed bench for as_gpio_seq_monitor: edge-mode and level-mode instances share stimulus.
module tb_as_gpio_seq_monitor;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned TO_W   = 16;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;
  logic [7:0] cfg_mask = '0;
  logic [4:0] cfg_len = '0;
  logic [15:0] to_limit = '0;
  logic       arm = 1'b0;
  logic       cs = 1'b0;
  logic [7:0] gpio = '0;

  int errors = 0;
  int checks = 0;

  logic [7:0] seq [8];

  always #5 clk = ~clk;

  as_gpio_seq_monitor_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) if1 ();
  as_gpio_seq_monitor_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W)) if0 ();

  assign if1.cfg_we_i = cfg_we;   assign if0.cfg_we_i = cfg_we;
  assign if1.cfg_addr_i = cfg_addr; assign if0.cfg_addr_i = cfg_addr;
  assign if1.cfg_data_i = cfg_data; assign if0.cfg_data_i = cfg_data;
  assign if1.cfg_mask_i = cfg_mask; assign if0.cfg_mask_i = cfg_mask;
  assign if1.cfg_len_i = cfg_len;   assign if0.cfg_len_i = cfg_len;
  assign if1.to_limit_i = to_limit; assign if0.to_limit_i = to_limit;
  assign if1.arm_i = arm;           assign if0.arm_i = arm;
  assign if1.cs_i = cs;             assign if0.cs_i = cs;
  assign if1.gpio_i = gpio;         assign if0.gpio_i = gpio;

  as_gpio_seq_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W), .EDGE_MODE(1)) dut1 (
    .clk_i(clk), .rstn_i(rstn), .bus(if1.slave)
  );
  as_gpio_seq_monitor #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_W(TO_W), .EDGE_MODE(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .bus(if0.slave)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_entry(input int unsigned a, input logic [7:0] d, input logic [7:0] m);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_data = d; cfg_mask = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic load_table();
    for (int unsigned i = 0; i < 8; i++) write_entry(i, seq[i], 8'hFF);
  endtask

  task automatic do_arm(input logic [4:0] len, input logic [15:0] lim);
    arm = 1'b1; cfg_len = len; to_limit = lim;
    tick();
    arm = 1'b0;
  endtask

  task automatic pulse(input logic [7:0] v);
    cs = 1'b1; gpio = v;
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  32'(if1.busy_o), 32'd0);
    check({tag, "_pass"},  32'(if1.pass_o), 32'd0);
    check({tag, "_fail"},  32'(if1.fail_o), 32'd0);
    check({tag, "_to"},    32'(if1.timeout_o), 32'd0);
    check({tag, "_step"},  32'(if1.step_o), 32'd0);
    check({tag, "_fidx"},  32'(if1.fail_idx_o), 32'd0);
    check({tag, "_fdata"}, 32'(if1.fail_data_o), 32'd0);
    check({tag, "_step0"}, 32'(if0.step_o), 32'd0);
  endtask

  initial begin
    seq[0] = 8'h01; seq[1] = 8'h02; seq[2] = 8'h03; seq[3] = 8'h04;
    seq[4] = 8'h05; seq[5] = 8'h06; seq[6] = 8'h07; seq[7] = 8'h80;

    repeat (2) tick();
    check_idle_outputs("reset");
    rstn = 1'b1;
    tick();
    load_table();

    // Full matching sequence, step counting and 1-cycle pass latency
    do_arm(5'd8, 16'd0);
    check("t1_busy", 32'(if1.busy_o), 32'd1);
    check("t1_step0", 32'(if1.step_o), 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      cs = 1'b1; gpio = seq[i];
      if (i == 7) check("t1_pass_pre", 32'(if1.pass_o), 32'd0);
      tick();
      check($sformatf("t1_step%0d", i + 1), 32'(if1.step_o), 32'(i + 1));
      check($sformatf("t1_pass%0d", i + 1), 32'(if1.pass_o), (i == 7) ? 32'd1 : 32'd0);
      cs = 1'b0;
      tick();
    end
    check("t1_busy_end", 32'(if1.busy_o), 32'd0);
    check("t1_fail", 32'(if1.fail_o), 32'd0);
    check("t1_pass_lvl", 32'(if0.pass_o), 32'd1);

    // Mismatch on third event
    do_arm(5'd8, 16'd0);
    check("t2_pass_clr", 32'(if1.pass_o), 32'd0);
    pulse(8'h01); pulse(8'h02); pulse(8'h09);
    check("t2_fail", 32'(if1.fail_o), 32'd1);
    check("t2_fidx", 32'(if1.fail_idx_o), 32'd2);
    check("t2_fdata", 32'(if1.fail_data_o), 32'h09);
    check("t2_step", 32'(if1.step_o), 32'd2);
    check("t2_pass", 32'(if1.pass_o), 32'd0);
    check("t2_busy", 32'(if1.busy_o), 32'd0);
    pulse(8'h03);
    check("t2_ignored", 32'(if1.step_o), 32'd2);

    // cs held high: one event in edge mode, one per cycle in level mode
    do_arm(5'd8, 16'd0);
    check("t3_fail_clr", 32'(if1.fail_o), 32'd0);
    check("t3_fidx_clr", 32'(if1.fail_idx_o), 32'd0);
    cs = 1'b1; gpio = 8'h01;
    repeat (4) tick();
    cs = 1'b0;
    tick();
    pulse(8'h02);
    check("t3e_step", 32'(if1.step_o), 32'd2);
    check("t3e_fail", 32'(if1.fail_o), 32'd0);
    check("t3l_fail", 32'(if0.fail_o), 32'd1);
    check("t3l_fidx", 32'(if0.fail_idx_o), 32'd1);
    check("t3l_fdata", 32'(if0.fail_data_o), 32'h01);
    check("t3l_step", 32'(if0.step_o), 32'd1);

    // Re-arm while armed restarts; arm together with an event ignores the event
    arm = 1'b1; cs = 1'b1; gpio = 8'h01;
    tick();
    arm = 1'b0; cs = 1'b0;
    tick();
    check("t4_rearm_step", 32'(if1.step_o), 32'd0);
    check("t4_rearm_busy", 32'(if1.busy_o), 32'd1);

    // Masked entry 7 then an overrun event after pass
    write_entry(7, 8'h80, 8'h80);
    do_arm(5'd8, 16'd0);
    for (int unsigned i = 0; i < 7; i++) pulse(seq[i]);
    pulse(8'hFF);
    check("t4_pass", 32'(if1.pass_o), 32'd1);
    check("t4_step", 32'(if1.step_o), 32'd8);
    pulse(8'h55);
    check("t4_ovr_fail", 32'(if1.fail_o), 32'd1);
    check("t4_ovr_pass", 32'(if1.pass_o), 32'd0);
    check("t4_ovr_fidx", 32'(if1.fail_idx_o), 32'd7);
    check("t4_ovr_fdata", 32'(if1.fail_data_o), 32'h55);

    // Length 0 behaves as length 1
    do_arm(5'd0, 16'd0);
    pulse(8'h01);
    check("t4_len0_pass", 32'(if1.pass_o), 32'd1);
    check("t4_len0_step", 32'(if1.step_o), 32'd1);

    // Watchdog fires exactly 50 cycles after the last event
    do_arm(5'd8, 16'd50);
    pulse(8'h01);
    cs = 1'b1; gpio = 8'h02;
    tick();
    cs = 1'b0; gpio = 8'h33;
    repeat (49) tick();
    check("t5_pre_fail", 32'(if1.fail_o), 32'd0);
    check("t5_pre_busy", 32'(if1.busy_o), 32'd1);
    tick();
    check("t5_fail", 32'(if1.fail_o), 32'd1);
    check("t5_to", 32'(if1.timeout_o), 32'd1);
    check("t5_fidx", 32'(if1.fail_idx_o), 32'd2);
    check("t5_fdata", 32'(if1.fail_data_o), 32'h33);
    check("t5_step", 32'(if1.step_o), 32'd2);

    // Event on the 50th cycle wins over the watchdog
    do_arm(5'd8, 16'd50);
    check("t5b_to_clr", 32'(if1.timeout_o), 32'd0);
    pulse(8'h01);
    cs = 1'b1; gpio = 8'h02;
    tick();
    cs = 1'b0;
    repeat (49) tick();
    cs = 1'b1; gpio = 8'h03;
    tick();
    cs = 1'b0;
    check("t5b_fail", 32'(if1.fail_o), 32'd0);
    check("t5b_to", 32'(if1.timeout_o), 32'd0);
    check("t5b_step", 32'(if1.step_o), 32'd3);
    tick();

    // Asynchronous reset mid-run, then a full passing run
    load_table();
    do_arm(5'd8, 16'd0);
    for (int unsigned i = 0; i < 4; i++) pulse(seq[i]);
    check("t6_step4", 32'(if1.step_o), 32'd4);
    rstn = 1'b0;
    #2;
    check_idle_outputs("t6_rst");
    rstn = 1'b1;
    tick();
    load_table();
    do_arm(5'd8, 16'd0);
    for (int unsigned i = 0; i < 8; i++) pulse(seq[i]);
    check("t6_pass", 32'(if1.pass_o), 32'd1);
    check("t6_fail", 32'(if1.fail_o), 32'd0);
    check("t6_step", 32'(if1.step_o), 32'd8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
